eq_level_packer: RTL
====================

Name: eq_level_packer

Overview:
- Upstream producer of the 32-bit `eqVals` word and the `done` flag consumed by the SPI shift-out stage.
- Receives per-band magnitudes from the filter-bank/FFT stage, one band per valid strobe.
- Tracks the peak magnitude of each of 8 bands over a frame of `FRAME_SETS` complete band sets.
- At frame end, quantizes each peak to a 4-bit log level, packs the eight levels into `eqVals`, and holds `done` until the MCU requests a new frame via `load`.

Parameters:
- MAG_W, 16, width of an input band magnitude.
- FRAME_SETS, 64, number of completed band sets (band 7 samples) per frame; must be ≥1.
- CNT_W, 8, width of the set counter; must satisfy 2^CNT_W > FRAME_SETS.

Ports:
- clk  input  1  system clock (HSOSC domain)
- nreset  input  1  asynchronous active-low reset
- load  input  1  MCU request. High means clear and hold off; the falling edge starts a frame. Synchronized here with a 2-flop synchronizer.
- sample_valid  input  1  one-cycle strobe; band_idx and band_mag are valid
- band_idx  input  3  band number 0..7 of the current magnitude
- band_mag  input  MAG_W  unsigned band magnitude
- eqVals  output  32  packed levels: band k in bits [4k+3:4k]
- done  output  1  frame result valid; held high until load is seen high
- busy  output  1  high in ACCUM and QUANT

Behaviour:
- Reset (nreset low, asynchronous) clears everything:
  - state=IDLE, eqVals=0, done=0, busy=0;
  - all 8 peak registers=0, set counter=0, quantize index=0, synchronizer flops=0.
- load_s denotes the synchronized load signal (2 clk latency).
- IDLE:
  - peaks cleared, counter cleared, done=0, eqVals holds its last value;
  - transition to ACCUM on the first cycle with load_s=0.
- ACCUM:
  - On sample_valid, peak[band_idx] <= max(peak[band_idx], band_mag); an equal value leaves the register unchanged.
  - On sample_valid with band_idx==7, the counter increments.
  - When the counter reaches FRAME_SETS, the state goes to QUANT on the next cycle. The band-7 sample in that cycle still updates peak[7] first.
  - Partial sets are legal; only band-7 strobes advance the counter.
- QUANT:
  - One band per cycle, index 0..7, so 8 cycles total.
  - level = 0 if peak==0; otherwise (msb_position(peak)+1), clipped to 15.
  - Example: peak=1 gives 1, peak=0x00FF gives 8, peak ≥0x4000 gives 15.
  - Levels are written into a shadow register. eqVals is updated from the shadow as a whole word in the same cycle that done rises, so eqVals never shows a half-updated frame.
  - sample_valid is ignored in this state.
- DONE:
  - done=1, eqVals stable; sample_valid is ignored.
  - Transition to IDLE when load_s=1; done falls in the same edge.
- Latency: from the clk edge capturing the final band-7 sample to done=1 is 9 clk cycles (8 quantize + 1 publish).
- load_s=1 in ACCUM or QUANT aborts to IDLE. eqVals keeps the previous frame's value and done stays 0.
- load_s=1 on the same cycle as the final band-7 sample: load wins and the result is discarded.
- The counter never wraps in normal operation, because the state leaves ACCUM exactly at FRAME_SETS.
- busy = (state==ACCUM || state==QUANT).
- Reset mid-frame: immediate asynchronous clear as above. The downstream SPI stage sees done=0.
- done only changes on clk edges and is glitch-free. It is sampled asynchronously by the SPI stage on sck.

Test Plan:
- Reset: nreset low with random inputs -> eqVals=0x00000000, done=0, busy=0; after release with load=0, busy=1 within 3 cycles.
- Full frame (FRAME_SETS=2): for 2 sets, band k magnitude = 1<<(2k); second set all 0 -> eqVals=0xFDB97531 (levels 1,3,5,7,9,11,13,15), done=1 exactly 9 cycles after the last band-7 strobe.
- Peak hold and clip: band 3 gets 0x0010 then 0xFFFF then 0x0001 -> level 15 in bits [15:12]; band 0 never strobed -> bits [3:0]=0.
- Handshake: hold load=0 after done -> done stays high and eqVals stays stable for 1000 cycles; pulse load high -> done low 3 cycles later, state IDLE; load low -> new frame starts.
- Abort: raise load halfway through a frame -> done stays 0, eqVals retains the previous frame's word; the next full frame then reports fresh peaks only.
- Simultaneous events: load_s rises on the cycle of the final band-7 strobe -> no QUANT and done=0; samples presented during QUANT/DONE do not alter the result.

Source files
------------

// File: rtl/eq_level_packer.sv
// eq_level_packer: tracks per-band peak magnitudes over a frame of complete
// band sets, converts each peak to a 4-bit log level and publishes the eight
// levels as one word with a done flag held until the MCU asks for a new frame.
module eq_level_packer #(
    parameter int unsigned MAG_W      = 16,
    parameter int unsigned FRAME_SETS = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic             sample_valid,
    input  logic [2:0]       band_idx,
    input  logic [MAG_W-1:0] band_mag,
    output logic [31:0]      eqVals,
    output logic             done,
    output logic             busy
);

    localparam int unsigned N_BANDS = 8;
    localparam int unsigned LVL_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned WORD_W  = N_BANDS * LVL_W;
    localparam int unsigned LVL_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_QUANT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic                           load_meta_q, load_s_q;
    logic [N_BANDS-1:0][MAG_W-1:0]  peak_q, peak_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               qidx_q, qidx_d;
    logic [WORD_W-1:0]              shadow_q, shadow_d;
    logic [WORD_W-1:0]              eq_q, eq_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;
    logic [LVL_W-1:0]               level_c;

    // Log level: 0 for a zero peak, else MSB position + 1, saturated at 15.
    function automatic logic [LVL_W-1:0] log_level(input logic [MAG_W-1:0] mag);
        int unsigned lvl;
        lvl = 0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (mag[i]) lvl = i + 1;
        end
        if (lvl > LVL_MAX) lvl = LVL_MAX;
        return LVL_W'(lvl);
    endfunction

    // Level of the band currently selected by the quantize index.
    always_comb begin
        level_c = log_level(peak_q[qidx_q]);
    end

    // Next-state and datapath updates; done/busy follow the next state so they
    // are registered and change only on clk edges.
    always_comb begin
        state_d  = state_q;
        peak_d   = peak_q;
        cnt_d    = cnt_q;
        qidx_d   = qidx_q;
        shadow_d = shadow_q;
        eq_d     = eq_q;

        case (state_q)
            ST_IDLE: begin
                peak_d = '0;
                cnt_d  = '0;
                qidx_d = '0;
                if (!load_s_q) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (load_s_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(FRAME_SETS)) begin
                    // Frame complete: samples arriving now belong to no frame.
                    state_d = ST_QUANT;
                    qidx_d  = '0;
                end else if (sample_valid) begin
                    if (band_mag > peak_q[band_idx]) peak_d[band_idx] = band_mag;
                    if (band_idx == IDX_W'(N_BANDS - 1)) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_QUANT: begin
                if (load_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    shadow_d[LVL_W * 32'(qidx_q) +: LVL_W] = level_c;
                    qidx_d = qidx_q + IDX_W'(1);
                    if (qidx_q == IDX_W'(N_BANDS - 1)) begin
                        // Publish the whole word together with done.
                        eq_d    = shadow_d;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (load_s_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_ACCUM) || (state_d == ST_QUANT);
    end

    // State, synchronizer and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            load_meta_q <= 1'b0;
            load_s_q    <= 1'b0;
            peak_q      <= '0;
            cnt_q       <= '0;
            qidx_q      <= '0;
            shadow_q    <= '0;
            eq_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_meta_q <= load;
            load_s_q    <= load_meta_q;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            qidx_q      <= qidx_d;
            shadow_q    <= shadow_d;
            eq_q        <= eq_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign eqVals = eq_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
